aes_round_sequencer: RTL

- Control FSM for the AES-128 decryption datapath.
- Loads ciphertext and key, then runs key expansion for a fixed cycle count.
- Issues the inverse-round operation schedule (AddRoundKey, InvShiftRows, InvSubBytes, InvMixColumns one column per cycle) with round-key index and column index.
- Handshakes with software through AES_START/AES_DONE; sits between the register interface and the datapath muxes.

---
 rtl/aes_seq_pkg.sv | 43 ++++
 rtl/aes_round_sequencer_mod_counter.sv | 45 ++++
 rtl/aes_round_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : aes_seq_pkg
//  Purpose : Shared types and constants for the AES-128 decryption round
//            sequencer: datapath operation codes, sequencer state encoding
//            and default schedule lengths.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package aes_seq_pkg;

  // Datapath operation selected through op_sel
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_KEYEXP = 3'd1,
    OP_ARK    = 3'd2,
    OP_ISR    = 3'd3,
    OP_ISB    = 3'd4,
    OP_IMC    = 3'd5
  } op_t;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_KEYEXP = 4'd2,
    S_ARK0   = 4'd3,
    S_R_ISR  = 4'd4,
    S_R_ISB  = 4'd5,
    S_R_ARK  = 4'd6,
    S_R_IMC  = 4'd7,
    S_F_ISR  = 4'd8,
    S_F_ISB  = 4'd9,
    S_F_ARK  = 4'd10,
    S_DONE   = 4'd11
  } seq_state_t;

  localparam int NUM_COLS          = 4;
  localparam int DEF_KEYEXP_CYCLES = 25;
  localparam int DEF_NUM_ROUNDS    = 10;

endpackage
`default_nettype wire

// File: rtl/aes_round_sequencer_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module  : mod_counter
//  Purpose : Modulo counter 0..MAX with synchronous clear and enable. Wraps
//            to zero on the enabled cycle after reaching MAX.
//  Ports   : CLK    in   clock, rising edge
//            RESET  in   asynchronous active-low reset
//            clr    in   synchronous clear (priority over en)
//            en     in   count enable
//            count  out  current count
//            at_max out  count == MAX
//  Rev     : 1.0  initial release
// ============================================================================
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      // explicit wrap at the terminal value, never by width overflow
      r_count <= (r_count == C_MAX) ? '0 : r_count + WIDTH'(1);
    end
  end

  assign count  = r_count;
  assign at_max = (r_count == C_MAX);

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : aes_round_sequencer
//  Purpose : Control FSM for the AES-128 decryption datapath. Loads
//            ciphertext/key, runs key expansion for KEYEXP_CYCLES cycles,
//            then issues the inverse-round schedule and handshakes with
//            software via AES_START / AES_DONE.
//  Ports   : CLK        in   clock, rising edge
//            RESET      in   asynchronous active-low reset
//            AES_START  in   level start request
//            AES_DONE   out  result valid, held until AES_START drops
//            busy       out  sequencer active
//            in_ld      out  load ciphertext into state register
//            key_ld     out  load cipher key into key schedule
//            op_sel     out  datapath operation (op_t)
//            state_ld   out  write datapath result into state register
//            round_idx  out  round-key index for AddRoundKey
//            col_idx    out  InvMixColumns column
//  Rev     : 1.0  initial release
// ============================================================================
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int KEYEXP_CYCLES = DEF_KEYEXP_CYCLES,
  parameter int NUM_ROUNDS    = DEF_NUM_ROUNDS
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       busy,
  output logic       in_ld,
  output logic       key_ld,
  output logic [2:0] op_sel,
  output logic       state_ld,
  output logic [3:0] round_idx,
  output logic [1:0] col_idx
);

  localparam logic [3:0] C_NR       = 4'(NUM_ROUNDS);
  localparam logic [3:0] C_LAST_MID = 4'(NUM_ROUNDS - 1);

  seq_state_t r_state;

  logic [4:0] w_kx_count_unused;
  logic       w_kx_last;
  logic [1:0] w_col_cnt;
  logic       w_col_last;
  logic [3:0] w_rnd_cnt;
  logic       w_rnd_wrap_unused;
  logic [3:0] w_ridx;

  // Key-expansion cycle counter: runs only while in KEYEXP
  mod_counter #(.WIDTH(5), .MAX(KEYEXP_CYCLES - 1)) u_kx_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (r_state != S_KEYEXP),
    .en     (r_state == S_KEYEXP),
    .count  (w_kx_count_unused),
    .at_max (w_kx_last)
  );

  // InvMixColumns column counter: runs only while in R_IMC
  mod_counter #(.WIDTH(2), .MAX(NUM_COLS - 1)) u_col_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (r_state != S_R_IMC),
    .en     (r_state == S_R_IMC),
    .count  (w_col_cnt),
    .at_max (w_col_last)
  );

  // Round counter: ARK0 moves it 0->1, each completed middle round adds one,
  // so it reads NUM_ROUNDS during the final round.
  mod_counter #(.WIDTH(4), .MAX(NUM_ROUNDS)) u_rnd_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    ((r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE)),
    .en     ((r_state == S_ARK0) || ((r_state == S_R_IMC) && w_col_last)),
    .count  (w_rnd_cnt),
    .at_max (w_rnd_wrap_unused)
  );

  // Round-key index for round states; naturally 0 in the final round
  assign w_ridx = C_NR - w_rnd_cnt;

  // Outputs are registered decodes of the current state and counters, so
  // they trail the state register by one cycle and never see AES_START
  // combinationally.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      AES_DONE  <= 1'b0;
      busy      <= 1'b0;
      in_ld     <= 1'b0;
      key_ld    <= 1'b0;
      op_sel    <= OP_NOP;
      state_ld  <= 1'b0;
      round_idx <= '0;
      col_idx   <= '0;
    end else begin
      AES_DONE  <= (r_state == S_DONE);
      busy      <= !((r_state == S_IDLE) || (r_state == S_DONE));
      in_ld     <= (r_state == S_LOAD);
      key_ld    <= (r_state == S_LOAD);
      op_sel    <= OP_NOP;
      state_ld  <= 1'b0;
      round_idx <= '0;
      col_idx   <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (AES_START) r_state <= S_LOAD;
        end
        S_LOAD: begin
          round_idx <= C_NR;
          r_state   <= S_KEYEXP;
        end
        S_KEYEXP: begin
          op_sel    <= OP_KEYEXP;
          round_idx <= C_NR;
          if (w_kx_last) r_state <= S_ARK0;
        end
        S_ARK0: begin
          op_sel    <= OP_ARK;
          state_ld  <= 1'b1;
          round_idx <= C_NR;
          r_state   <= S_R_ISR;
        end
        S_R_ISR: begin
          op_sel    <= OP_ISR;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          r_state   <= S_R_ISB;
        end
        S_R_ISB: begin
          op_sel    <= OP_ISB;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          r_state   <= S_R_ARK;
        end
        S_R_ARK: begin
          op_sel    <= OP_ARK;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          r_state   <= S_R_IMC;
        end
        S_R_IMC: begin
          op_sel    <= OP_IMC;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          col_idx   <= w_col_cnt;
          // the round counter increments on this same edge, so the last
          // middle round is recognised by its pre-increment value
          if (w_col_last)
            r_state <= (w_rnd_cnt == C_LAST_MID) ? S_F_ISR : S_R_ISR;
        end
        S_F_ISR: begin
          op_sel    <= OP_ISR;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          r_state   <= S_F_ISB;
        end
        S_F_ISB: begin
          op_sel    <= OP_ISB;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          r_state   <= S_F_ARK;
        end
        S_F_ARK: begin
          op_sel    <= OP_ARK;
          state_ld  <= 1'b1;
          round_idx <= w_ridx;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          // a new run needs AES_START to go low first
          if (!AES_START) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
